alu_mul_seq: RTL
================

// Module: alu_mul_seq
// PURPOSE
//  Sequential signed 32x32 multiplier using radix-4 Booth (bit-pair) recoding; 64-bit product on HI/LO.
//  Multiplicative counterpart to the ALU's non-restoring divider; feeds the MiniSRC HI/LO registers for MUL.
//  Operands are captured on a start pulse. Result is ready WIDTH/2 iterations later, flagged by a 1-cycle done.
// PARAMETERS
//  WIDTH   32   operand width; even, >=4; product is 2*WIDTH bits
// PORTS
//  clock   in   1        system clock; all state updates on rising edge
//  clear   in   1        asynchronous, active-high reset
//  start   in   1        request; sampled only in IDLE or DONE
//  A       in   WIDTH    signed multiplicand (two's complement)
//  B       in   WIDTH    signed multiplier (two's complement)
//  busy    out  1        high while state==RUN
//  done    out  1        1-cycle pulse: HI/LO valid
//  HI      out  WIDTH    product[2W-1:W], held until next accepted start
//  LO      out  WIDTH    product[W-1:0], held until next accepted start
//  OVF     out  1        only with ALU_MUL_OVF_EN (see CONFIGURATION)
// BEHAVIOUR
//  Clock/reset: single clock domain, clock; clear is asynchronous and active-high.
//  Reset: clear high -> state=IDLE; busy=0, done=0, HI=0, LO=0, OVF=0; counter and accumulator =0. Reset mid-RUN aborts; no done.
//  FSM IDLE -> RUN: start=1 at edge E. Latch M=A (sign-extended to W+2), Q=B, q_m1=0, acc=0, cnt=W/2.
//  FSM RUN -> RUN: each edge handles one Booth digit d from {Q[1],Q[0],q_m1}.
//    Digit map: 000,111=0; 001,010=+M; 011=+2M; 100=-2M; 101,110=-M.
//    acc(W+2 bits) += d*M; then {acc,Q,q_m1} arithmetic right shift by 2; cnt--.
//  FSM RUN -> DONE: edge where cnt reaches 0 (E+W/2). HI={acc}[W-1:0], LO=Q; done=1 for exactly one cycle.
//  FSM DONE -> IDLE: next edge with start=0.
//  FSM DONE -> RUN: start=1 (back-to-back, no bubble). done drops; HI/LO keep old value until new done.
//  Latency: start edge to done high = W/2+1 edges (17 for W=32). Throughput: one op per W/2+1 cycles.
//  start while busy: ignored; operands not re-latched; in-flight op unaffected.
//  A/B: may change freely after the start edge.
//  Arithmetic: acc is W+2 bits so +/-2M never overflows. Sign extension must be arithmetic in the shift.
//  Corner case: -2^(W-1) * -2^(W-1) = 2^(2W-2) must be exact.
//  Zero operand: still takes full latency (no early exit); result 0.
// CONFIGURATION
//  ALU_MUL_OVF_EN defined: OVF port exists. At done, OVF=1 iff HI != {W{LO[W-1]}}, i.e. the product
//  does not fit in WIDTH signed bits. OVF is held with HI/LO and cleared by clear/accepted start.
//  ALU_MUL_OVF_EN undefined: no OVF port or logic; all other behaviour identical.
// STRUCTURE
//  Shared package alu_pkg:
//    state enum {IDLE,RUN,DONE}
//    booth_digit_t enum {ZERO,P1,P2,M1,M2}
//    localparam MUL_ITERS=WIDTH/2
//  Sub-module booth_r4_recode: combinational {Q[1],Q[0],q_m1} -> booth_digit_t.
//  Top holds the FSM, counter, acc/Q shift register, and the add/sub of M or 2M.
// TESTING
//  1 A=6, B=7, start -> done at start+17 cycles; HI=0, LO=0x0000002A; busy high 16 cycles.
//  2 A=-1, B=1 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF. A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0.
//  3 A=B=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001. With ALU_MUL_OVF_EN: OVF=1; for 6*7, OVF=0.
//  4 start=1 with A=3, B=5 at cycle 5 of a RUN of 9*9 -> ignored; result HI=0, LO=0x51; single done pulse.
//  5 clear asserted mid-RUN (cycle 8), async between edges -> outputs 0 immediately, no done.
//    Then 2*-3 -> LO=0xFFFFFFFA, HI=0xFFFFFFFF.
//  6 start held in DONE cycle with A=-4, B=-5 -> RUN resumes next edge; second done 17 cycles later.
//    Result LO=0x14; first result stable until then.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU multiply path: FSM states, radix-4 Booth digits, iteration count.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    P1,
    P2,
    M1,
    M2
  } booth_digit_t;

  localparam int ALU_WIDTH = 32;
  localparam int MUL_ITERS = ALU_WIDTH / 2;

  // Maps the overlapping bit triple {q[1], q[0], q[-1]} onto a signed Booth digit.
  function automatic booth_digit_t booth_decode(input logic [2:0] bits);
    booth_digit_t d;
    case (bits)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Combinational radix-4 Booth recoder: one multiplier bit-pair plus the previous bit -> digit.
module booth_r4_recode
  import alu_pkg::*;
(
  input  logic [2:0]   bits,
  output booth_digit_t digit
);

  assign digit = booth_decode(bits);

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential signed WIDTH x WIDTH radix-4 Booth multiplier, two multiplier bits per clock.
// Optional OVF output (product does not fit in WIDTH signed bits) under `ALU_MUL_OVF_EN.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
`ifdef ALU_MUL_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int AW    = WIDTH + 2;
  localparam int ITERS = WIDTH / 2;
  localparam int CW    = $clog2(ITERS + 1);
  localparam int TOP   = AW + WIDTH;

  state_t         state;
  logic [AW-1:0]  m_reg;
  logic [AW-1:0]  acc;
  logic [WIDTH-1:0] q_reg;
  logic           q_m1;
  logic [CW-1:0]  cnt;

  booth_digit_t   digit;
  logic [AW-1:0]  addend;
  logic [AW-1:0]  acc_sum;
  logic [TOP:0]   chain;
  logic [TOP:0]   chain_sh;
  logic [AW-1:0]  acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic           qm1_nxt;

  booth_r4_recode u_recode (
    .bits  ({q_reg[1:0], q_m1}),
    .digit (digit)
  );

  // acc is two bits wider than the operand so that +/-2M can never wrap.
  always_comb begin
    addend = '0;
    case (digit)
      P1:      addend = m_reg;
      P2:      addend = {m_reg[AW-2:0], 1'b0};
      M1:      addend = -m_reg;
      M2:      addend = -{m_reg[AW-2:0], 1'b0};
      default: addend = '0;
    endcase
    acc_sum  = acc + addend;
    chain    = {acc_sum, q_reg, q_m1};
    chain_sh = {{2{chain[TOP]}}, chain[TOP:2]};
    acc_nxt  = chain_sh[TOP:WIDTH+1];
    q_nxt    = chain_sh[WIDTH:1];
    qm1_nxt  = chain_sh[0];
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      m_reg <= '0;
      acc   <= '0;
      q_reg <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
`ifdef ALU_MUL_OVF_EN
      OVF   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m_reg <= {{2{A[WIDTH-1]}}, A};
            q_reg <= B;
            q_m1  <= 1'b0;
            acc   <= '0;
            cnt   <= CW'(ITERS);
            busy  <= 1'b1;
            state <= RUN;
`ifdef ALU_MUL_OVF_EN
            OVF   <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          q_reg <= q_nxt;
          q_m1  <= qm1_nxt;
          cnt   <= cnt - CW'(1);
          // Last digit: publish the shifted result directly so done lines up with HI/LO.
          if (cnt == CW'(1)) begin
            HI    <= acc_nxt[WIDTH-1:0];
            LO    <= q_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
`ifdef ALU_MUL_OVF_EN
            OVF   <= (acc_nxt[WIDTH-1:0] != {WIDTH{q_nxt[WIDTH-1]}});
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
